// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM command sequencer: command encodings,
// FSM state encodings and a small elaboration-time helper.
// The refresh states are only reached when DRAM_REFRESH_EN is defined.
package dram_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_PREA = 3'd5,
        CMD_REF  = 3'd6
    } cmd_e;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE   = 4'd0;
    localparam logic [STATE_W-1:0] ST_PRE    = 4'd1;
    localparam logic [STATE_W-1:0] ST_TRP    = 4'd2;
    localparam logic [STATE_W-1:0] ST_ACT    = 4'd3;
    localparam logic [STATE_W-1:0] ST_TRCD   = 4'd4;
    localparam logic [STATE_W-1:0] ST_ACCESS = 4'd5;
    localparam logic [STATE_W-1:0] ST_TCL    = 4'd6;
    localparam logic [STATE_W-1:0] ST_PREA   = 4'd7;
    localparam logic [STATE_W-1:0] ST_TRFC   = 4'd8;
    localparam logic [STATE_W-1:0] ST_REF    = 4'd9;

    // Larger of two integers, used to size the shared wait timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_timer.sv
// Wait-state down-counter. Loading puts a value in; the counter then
// decrements once per cycle and holds at zero, where expired is high.
module dram_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count_q, count_d;

    // Next count: load wins, otherwise count down and stick at zero.
    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for state so every flop samples pre-edge values.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Single-request DRAM command sequencer with an open-row table.
// A request is turned into PRE/ACT/RD/WR commands spaced by T_RP, T_RCD and
// T_CL, then done pulses. Optional periodic refresh (PREA + REF) is built
// when the macro DRAM_REFRESH_EN is defined.
module dram_cmd_sequencer
    import dram_pkg::*;
#(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RCD        = 3,
    parameter int T_RP         = 2,
    parameter int T_CL         = 4,
    parameter int T_REFI       = 780,
    parameter int T_RFC        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] bank_id,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]  row_id,
    input  logic [$clog2(NUM_OF_COLS)-1:0]  col_id,
    output logic [2:0]                      cmd,
    output logic [$clog2(NUM_OF_BANKS)-1:0] cmd_bank,
    output logic [$clog2(NUM_OF_ROWS)-1:0]  cmd_row,
    output logic [$clog2(NUM_OF_COLS)-1:0]  cmd_col,
    output logic                            done
);

    localparam int BW = $clog2(NUM_OF_BANKS);
    localparam int RW = $clog2(NUM_OF_ROWS);
    localparam int CW = $clog2(NUM_OF_COLS);
    localparam int TW = $clog2(max_int(max_int(T_RCD, T_RP), max_int(T_CL, T_RFC)) + 1);

    if (T_RCD < 1 || T_RP < 1 || T_CL < 1 || T_RFC < 1 || T_REFI < 1) begin : g_bad_timing
        $error("dram_cmd_sequencer: all timing parameters must be >= 1");
    end

    logic [STATE_W-1:0]   state_q, state_d;
    logic                 write_q, write_d;
    logic [BW-1:0]        bank_q, bank_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic [2:0]           cmd_q, cmd_d;
    logic [BW-1:0]        cmd_bank_q, cmd_bank_d;
    logic [RW-1:0]        cmd_row_q, cmd_row_d;
    logic [CW-1:0]        cmd_col_q, cmd_col_d;
    logic                 done_q, done_d;
    logic [NUM_OF_BANKS-1:0] open_q, open_d;
    logic [RW-1:0]        row_tbl_q [NUM_OF_BANKS];
    logic                 row_we;
    logic                 tmr_load;
    logic [TW-1:0]        tmr_val;
    logic                 tmr_expired;

`ifdef DRAM_REFRESH_EN
    localparam int RFW = $clog2(T_REFI + 1);
    logic [RFW-1:0] refi_q, refi_d;
    logic           pend_q, pend_d;
    logic           in_ref_q, in_ref_d;
    logic           ref_done;
`endif

    dram_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .value   (tmr_val),
        .expired (tmr_expired)
    );

    // Next-state logic: route each accepted request by open-row lookup.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        bank_d  = bank_q;
        row_d   = row_q;
        col_d   = col_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    write_d = req_write;
                    bank_d  = bank_id;
                    row_d   = row_id;
                    col_d   = col_id;
                    if (!open_q[bank_id])                 state_d = ST_ACT;
                    else if (row_tbl_q[bank_id] == row_id) state_d = ST_ACCESS;
                    else                                  state_d = ST_PRE;
                end
`ifdef DRAM_REFRESH_EN
                else if (pend_q) begin
                    state_d = ST_PREA;
                end
`endif
            end
            ST_PRE:  state_d = tmr_expired ? ST_ACT : ST_TRP;
            ST_TRP: begin
                if (tmr_expired) begin
`ifdef DRAM_REFRESH_EN
                    state_d = in_ref_q ? ST_REF : ST_ACT;
`else
                    state_d = ST_ACT;
`endif
                end
            end
            ST_ACT:  state_d = tmr_expired ? ST_ACCESS : ST_TRCD;
            ST_TRCD: if (tmr_expired) state_d = ST_ACCESS;
            ST_ACCESS, ST_TCL: begin
                if (tmr_expired) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_TCL;
                end
            end
`ifdef DRAM_REFRESH_EN
            ST_PREA: state_d = tmr_expired ? ST_REF : ST_TRP;
            ST_REF:  state_d = tmr_expired ? ST_IDLE : ST_TRFC;
            ST_TRFC: if (tmr_expired) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Command, timer load and open-table update for the state being entered.
    always_comb begin
        cmd_d      = CMD_NOP;
        cmd_bank_d = '0;
        cmd_row_d  = '0;
        cmd_col_d  = '0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        open_d     = open_q;
        row_we     = 1'b0;
        case (state_d)
            ST_ACT: begin
                cmd_d          = CMD_ACT;
                cmd_bank_d     = bank_d;
                cmd_row_d      = row_d;
                tmr_load       = 1'b1;
                tmr_val        = TW'(T_RCD - 1);
                open_d[bank_d] = 1'b1;
                row_we         = 1'b1;
            end
            ST_PRE: begin
                cmd_d          = CMD_PRE;
                cmd_bank_d     = bank_d;
                tmr_load       = 1'b1;
                tmr_val        = TW'(T_RP - 1);
                open_d[bank_d] = 1'b0;
            end
            ST_ACCESS: begin
                cmd_d      = write_d ? CMD_WR : CMD_RD;
                cmd_bank_d = bank_d;
                cmd_col_d  = col_d;
                tmr_load   = 1'b1;
                tmr_val    = TW'(T_CL - 1);
            end
`ifdef DRAM_REFRESH_EN
            ST_PREA: begin
                cmd_d    = CMD_PREA;
                tmr_load = 1'b1;
                tmr_val  = TW'(T_RP - 1);
                open_d   = '0;
            end
            ST_REF: begin
                cmd_d    = CMD_REF;
                tmr_load = 1'b1;
                tmr_val  = TW'(T_RFC - 1);
            end
`endif
            default: ;
        endcase
    end

    // FSM, latched request and registered command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            bank_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            cmd_q      <= CMD_NOP;
            cmd_bank_q <= '0;
            cmd_row_q  <= '0;
            cmd_col_q  <= '0;
            done_q     <= 1'b0;
            open_q     <= '0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            bank_q     <= bank_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cmd_q      <= cmd_d;
            cmd_bank_q <= cmd_bank_d;
            cmd_row_q  <= cmd_row_d;
            cmd_col_q  <= cmd_col_d;
            done_q     <= done_d;
            open_q     <= open_d;
        end
    end

    // Open-row register file, written on every ACT.
    always_ff @(posedge clk) begin
        // NOTE: the row table is not reset; its contents only matter when open_q is set.
        if (row_we) begin
            row_tbl_q[bank_d] <= row_d;
        end
    end

`ifdef DRAM_REFRESH_EN
    assign ref_done = in_ref_q && tmr_expired && (state_q == ST_REF || state_q == ST_TRFC);

    // Refresh interval counter, pending request and in-refresh flag.
    always_comb begin
        refi_d   = (refi_q == '0) ? RFW'(T_REFI - 1) : refi_q - RFW'(1);
        pend_d   = pend_q;
        in_ref_d = in_ref_q;
        if (ref_done) begin
            pend_d   = 1'b0;
            in_ref_d = 1'b0;
        end
        if (state_d == ST_PREA) in_ref_d = 1'b1;
        if (refi_q == '0)       pend_d   = 1'b1;
    end

    // Refresh state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            refi_q   <= RFW'(T_REFI - 1);
            pend_q   <= 1'b0;
            in_ref_q <= 1'b0;
        end else begin
            refi_q   <= refi_d;
            pend_q   <= pend_d;
            in_ref_q <= in_ref_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE) && !done_q && !pend_q;
`else
    assign req_ready = (state_q == ST_IDLE) && !done_q;
`endif

    assign cmd      = cmd_q;
    assign cmd_bank = cmd_bank_q;
    assign cmd_row  = cmd_row_q;
    assign cmd_col  = cmd_col_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Scoreboard bench for dram_cmd_sequencer (default build, no refresh).
// The driver predicts each request's command timeline from the open-row
// rules and pushes it into a queue; a monitor pops and compares whenever
// the DUT shows a command or a done pulse.
module tb_dram_cmd_sequencer;

    localparam int NB = 8, NR = 128, NC = 8;
    localparam int T_RCD = 3, T_RP = 2, T_CL = 4;
    localparam int BW = $clog2(NB), RW = $clog2(NR), CW = $clog2(NC);
    localparam int K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4, K_DONE = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [BW-1:0] bank_id = '0;
    logic [RW-1:0] row_id = '0;
    logic [CW-1:0] col_id = '0;
    logic [2:0]    cmd;
    logic [BW-1:0] cmd_bank;
    logic [RW-1:0] cmd_row;
    logic [CW-1:0] cmd_col;
    logic          done;

    always #5 clk = ~clk;

    dram_cmd_sequencer #(
        .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
        .T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL), .T_REFI(780), .T_RFC(16)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .bank_id(bank_id), .row_id(row_id), .col_id(col_id),
        .cmd(cmd), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .done(done)
    );

    typedef struct {
        int cyc;
        int kind;
        int bank;
        int row;
        int col;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  ready_from = 0;
    bit  mon_en = 1'b0;
    bit  m_open[NB];
    int  m_row[NB];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input int k, input int b, input int r, input int co);
        ev_t e;
        e.cyc = c; e.kind = k; e.bank = b; e.row = r; e.col = co;
        exp_q.push_back(e);
    endtask

    // Reference model: command timeline for a request accepted in cycle a.
    task automatic model_accept(input int a, input bit w, input int b, input int r, input int c);
        int t;
        t = a + 1;
        if (!(m_open[b] && m_row[b] == r)) begin
            if (m_open[b]) begin
                push_ev(t, K_PRE, b, 0, 0);
                t += T_RP;
            end
            push_ev(t, K_ACT, b, r, 0);
            t += T_RCD;
            m_open[b] = 1'b1;
            m_row[b]  = r;
        end
        push_ev(t, w ? K_WR : K_RD, b, 0, c);
        push_ev(t + T_CL, K_DONE, 0, 0, 0);
        ready_from = t + T_CL + 1;
    endtask

    task automatic sb_pop(input int kind, input int b, input int r, input int c);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: kind %0d bank %0d row %0d col %0d at cycle %0d, nothing expected",
                     kind, b, r, c, cyc);
            return;
        end
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_kind", kind, e.kind);
        check("event_operands", b * 65536 + r * 256 + c, e.bank * 65536 + e.row * 256 + e.col);
    endtask

    // Monitor: samples outputs mid-cycle, independent of the driver.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event: kind %0d due at cycle %0d not seen by cycle %0d",
                         exp_q[0].kind, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (done) sb_pop(K_DONE, 0, 0, 0);
            if (cmd != 3'd0) sb_pop(int'(cmd), int'(cmd_bank), int'(cmd_row), int'(cmd_col));
            else check("nop_operands_zero", int'({cmd_bank, cmd_row, cmd_col}), 0);
        end
    end

    // One driver cycle: check ready against the model, drive inputs, model acceptance.
    task automatic step(input bit v, input bit w, input int b, input int r, input int c, output bit acc);
        bit exp_ready;
        @(negedge clk);
        #1;
        exp_ready = (cyc >= ready_from);
        check("req_ready", int'(req_ready), int'(exp_ready));
        req_valid = v;
        req_write = w;
        bank_id   = BW'(b);
        row_id    = RW'(r);
        col_id    = CW'(c);
        acc = v && exp_ready;
        if (acc) model_accept(cyc, w, b, r, c);
    endtask

    task automatic issue(input bit w, input int b, input int r, input int c);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            step(1'b1, w, b, r, c, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: bank %0d row %0d not accepted within 100 cycles", b, r);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, acc);
    endtask

    // Keep the current request on the bus (same data) for n cycles.
    task automatic hold(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b1, req_write, int'(bank_id), int'(row_id), int'(col_id), acc);
    endtask

    task automatic reset_checks();
        check("reset_cmd", int'(cmd), 0);
        check("reset_operands", int'({cmd_bank, cmd_row, cmd_col}), 0);
        check("reset_done", int'(done), 0);
        check("reset_ready", int'(req_ready), 1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b0;
        exp_q.delete();
        foreach (m_open[i]) m_open[i] = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        rst = 1'b0;
        ready_from = cyc;
        reset_checks();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        foreach (m_open[i]) m_open[i] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        ready_from = cyc;
        reset_checks();
        mon_en = 1'b1;

        // Closed bank, row hit, then row conflict with a write.
        issue(1'b0, 2, 5, 1);
        issue(1'b0, 2, 5, 3);
        idle(2);
        issue(1'b1, 2, 9, 4);
        idle(1);

        // Request held on the bus while busy must not be taken twice.
        issue(1'b0, 7, 127, 7);
        hold(3);
        idle(1);

        // Reset while waiting out T_RCD: no RD, no done, bank closed again.
        issue(1'b0, 6, 3, 2);
        idle(1);
        do_reset(1);
        issue(1'b0, 6, 3, 2);

        // Back-to-back with req_valid held high throughout.
        issue(1'b1, 6, 3, 0);
        issue(1'b0, 6, 4, 1);
        issue(1'b1, 0, 0, 0);
        issue(1'b0, 0, 0, 5);

        // Randomized mix over a few banks/rows to hit every path.
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, NC - 1));
            case ($urandom_range(0, 3))
                0: ;
                1: idle($urandom_range(1, 3));
                2: hold($urandom_range(1, 3));
                default: idle(1);
            endcase
        end

        idle(1);
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
